digital_clock_cfg: RTL and testbench
====================================

Name: digital_clock_cfg

Overview:
Parametrised successor to the team's free-running hh:mm:ss counter. Adds:
- An internal prescaler, so time advances once per TICK_DIV clocks rather than on every clock.
- Run/pause control and a synchronous time-load port with range checking.
- Runtime 12/24-hour display mode.
- A minute-resolution alarm and per-unit rollover pulses.
It sits between the system clock domain and display/alarm logic.

Parameters:
- TICK_DIV, 50_000_000: clocks per one-second tick. Legal range is ≥1; 1 means a tick every enabled clock.
- CNT_W, $clog2(TICK_DIV)+1: prescaler counter width. Derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting 0 clears all state immediately; deassertion is sampled on clk.
- run  in  1  1 = prescaler counts and time advances; 0 = prescaler and time hold.
- mode_12h  in  1  display mode: 0 = 24 h, 1 = 12 h with pm flag. Combinational effect on display outputs only.
- load  in  1  one-cycle request to load time from load_hr/load_min/load_sec.
- load_hr  in  5  load value, 0..23 (always 24 h format).
- load_min  in  6  load value, 0..59.
- load_sec  in  6  load value, 0..59.
- alarm_en  in  1  enables alarm matching.
- alarm_hr  in  5  alarm hour, 0..23.
- alarm_min  in  6  alarm minute, 0..59.
- seconds  out  6  current seconds, registered.
- minutes  out  6  current minutes, registered.
- hours  out  5  display hours: 0..23 in 24 h mode, 1..12 in 12 h mode.
- pm  out  1  1 when internal hour is ≥12. Valid in both modes.
- sec_pulse  out  1  one-cycle pulse on every seconds advance.
- min_pulse  out  1  one-cycle pulse when seconds wrap 59→0.
- hr_pulse  out  1  one-cycle pulse when minutes wrap 59→0.
- day_pulse  out  1  one-cycle pulse when hours wrap 23→0.
- load_err  out  1  one-cycle pulse when a load was rejected.
- alarm_hit  out  1  one-cycle pulse on alarm match.

Behaviour:
- Reset (rst=0): prescaler=0; internal time 00:00:00; all pulses=0. hours output shows 0 in 24 h mode and 12 in 12 h mode; pm=0.
- Internal hour is always kept 0..23. 12 h display mapping:
  - 0 → 12, pm=0
  - 1..11 → same, pm=0
  - 12 → 12, pm=1
  - 13..23 → h−12, pm=1
- Display outputs are combinational from the registered internal hour and mode_12h. mode_12h never alters the count.
- Prescaler, when run=1:
  - tick = (prescaler == TICK_DIV−1).
  - On tick, prescaler ← 0; otherwise prescaler ← prescaler+1.
- Prescaler, when run=0: prescaler and time hold; tick=0.
- Time advance on a tick edge:
  - seconds+1. At 59, seconds → 0 and minutes+1.
  - Minutes at 59 → 0 and hours+1.
  - Hours at 23 → 0.
  - Result: 23:59:59 → 00:00:00 in a single tick.
- Pulses are registered and high for exactly the one cycle after the advancing edge.
  - sec_pulse fires every tick.
  - min_pulse, hr_pulse and day_pulse fire on their respective wraps and are coincident with sec_pulse.
- Load is valid when load_hr≤23, load_min≤59 and load_sec≤59:
  - Time ← load values and prescaler ← 0.
  - Any tick in that same cycle is discarded.
  - No sec/min/hr/day pulses and no alarm_hit are produced by a load.
- Load is invalid when any field is out of range:
  - Time and prescaler are unchanged and a normal tick still applies.
  - load_err pulses for one cycle.
- Load is accepted regardless of run.
- Priority: rst > load > tick.
- Alarm: alarm_hit pulses (registered, coincident with sec_pulse) when all of these hold:
  - the new time produced by a tick has hours==alarm_hr, minutes==alarm_min and seconds==0;
  - alarm_en=1 in the tick cycle.
- Alarm fires at most once per matching minute. It never fires on load or reset.
- Out-of-range alarm values simply never match.
- Reset asserted mid-count clears immediately and asynchronously; no pulse is emitted.
- TICK_DIV=1: tick on every cycle while run=1.

Test Plan (TICK_DIV=4 unless stated):
- Reset, run=1 for 40 clocks → seconds=10, sec_pulse seen 10 times spaced 4 clocks; run=0 for 20 clocks → values frozen, no pulses.
- Load 23:59:58, run=1, 2 ticks → 23:59:59 then 00:00:00; the second tick pulses min_pulse, hr_pulse and day_pulse together with sec_pulse.
- Load 13:05:00, mode_12h=1 → hours=1, pm=1. Load 00:30:00 → hours=12, pm=0. Load 12:00:00 → hours=12, pm=1. Each with mode_12h=0 → 13/0/12.
- Load hr=24 min=0 sec=0 → load_err pulse, time unchanged; load min=60 → same; valid load in the tick cycle → loaded value wins, no sec_pulse.
- alarm_en=1, alarm 07:00, load 06:59:58, run → alarm_hit once on reaching 07:00:00; repeat with alarm_en=0 → no hit; load 07:00:00 directly → no hit.
- Drop rst to 0 mid-prescale, asynchronously between edges → outputs 00:00:00 before the next edge; release → counting resumes from a full TICK_DIV period.

Source files
------------

// File: rtl/digital_clock_cfg.sv
// hh:mm:ss time-of-day counter with a one-second prescaler, run/pause, checked time load,
// 12/24 h display, a minute-resolution alarm and registered rollover pulses.
module digital_clock_cfg #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [4:0] load_hr,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       pm,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       hr_pulse,
  output logic       day_pulse,
  output logic       load_err,
  output logic       alarm_hit
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  // Pulse vector bit order: {alarm_hit, load_err, day, hr, min, sec}
  localparam int P_SEC   = 0;
  localparam int P_MIN   = 1;
  localparam int P_HR    = 2;
  localparam int P_DAY   = 3;
  localparam int P_ERR   = 4;
  localparam int P_ALARM = 5;

  logic [CNT_W-1:0] presc_reg, presc_next;
  logic [5:0]       sec_reg, sec_next;
  logic [5:0]       min_reg, min_next;
  logic [4:0]       hr_reg, hr_next;
  logic [5:0]       pulse_reg, pulse_next;

  logic tick, load_ok;
  logic sec_wrap, min_wrap, hr_wrap;

  always_comb begin
    tick     = run && (presc_reg == TICK_LAST);
    load_ok  = load && (load_hr <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
    sec_wrap = (sec_reg == 6'd59);
    min_wrap = sec_wrap && (min_reg == 6'd59);
    hr_wrap  = min_wrap && (hr_reg == 5'd23);

    presc_next = presc_reg;
    sec_next   = sec_reg;
    min_next   = min_reg;
    hr_next    = hr_reg;
    pulse_next = '0;

    if (load_ok) begin
      // A valid load swallows any coincident tick and emits no pulses.
      presc_next = '0;
      sec_next   = load_sec;
      min_next   = load_min;
      hr_next    = load_hr;
    end else begin
      pulse_next[P_ERR] = load;
      if (run)
        presc_next = tick ? '0 : presc_reg + 1'b1;
      if (tick) begin
        sec_next = sec_wrap ? 6'd0 : sec_reg + 6'd1;
        if (sec_wrap)
          min_next = min_wrap ? 6'd0 : min_reg + 6'd1;
        if (min_wrap)
          hr_next = hr_wrap ? 5'd0 : hr_reg + 5'd1;
        pulse_next[P_SEC] = 1'b1;
        pulse_next[P_MIN] = sec_wrap;
        pulse_next[P_HR]  = min_wrap;
        pulse_next[P_DAY] = hr_wrap;
        // Only the tick landing on ss==00 can match, so one hit per matching minute.
        pulse_next[P_ALARM] = alarm_en && sec_wrap &&
                              (hr_next == alarm_hr) && (min_next == alarm_min);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg <= '0;
      sec_reg   <= '0;
      min_reg   <= '0;
      hr_reg    <= '0;
      pulse_reg <= '0;
    end else begin
      presc_reg <= presc_next;
      sec_reg   <= sec_next;
      min_reg   <= min_next;
      hr_reg    <= hr_next;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    hours = hr_reg;
    if (mode_12h) begin
      if (hr_reg == 5'd0)
        hours = 5'd12;
      else if (hr_reg > 5'd12)
        hours = hr_reg - 5'd12;
    end
  end

  assign pm        = (hr_reg >= 5'd12);
  assign seconds   = sec_reg;
  assign minutes   = min_reg;
  assign sec_pulse = pulse_reg[P_SEC];
  assign min_pulse = pulse_reg[P_MIN];
  assign hr_pulse  = pulse_reg[P_HR];
  assign day_pulse = pulse_reg[P_DAY];
  assign load_err  = pulse_reg[P_ERR];
  assign alarm_hit = pulse_reg[P_ALARM];

endmodule

// File: tb/tb_digital_clock_cfg.sv
// Directed bench for digital_clock_cfg with TICK_DIV=4; expected values are hand-computed.
module tb_digital_clock_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       mode_12h;
  logic       load;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       alarm_en;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       sec_pulse, min_pulse, hr_pulse, day_pulse, load_err, alarm_hit;

  int check_cnt = 0;
  int pass_cnt  = 0;

  digital_clock_cfg #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h),
    .load(load), .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
    .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .seconds(seconds), .minutes(minutes), .hours(hours), .pm(pm),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hr_pulse(hr_pulse),
    .day_pulse(day_pulse), .load_err(load_err), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    check_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges; outputs are sampled 1 ns after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hr"}, int'(hours), h);
    check({tag, ".min"}, int'(minutes), m);
    check({tag, ".sec"}, int'(seconds), s);
  endtask

  // One-cycle load request; drops load after the capturing edge.
  task automatic do_load(input int h, input int m, input int s);
    load_hr  = 5'(h);
    load_min = 6'(m);
    load_sec = 6'(s);
    load     = 1'b1;
    step(1);
    load     = 1'b0;
    $display("load %0d:%0d:%0d -> %0d:%0d:%0d err=%0b", h, m, s, hours, minutes, seconds, load_err);
  endtask

  initial begin
    int pcnt, first_idx, last_idx, bad_gap, hits;
    rst = 1'b0; run = 1'b0; mode_12h = 1'b0; load = 1'b0;
    load_hr = '0; load_min = '0; load_sec = '0;
    alarm_en = 1'b0; alarm_hr = '0; alarm_min = '0;

    step(2);
    rst = 1'b1;
    chk_time("reset", 0, 0, 0);
    check("reset.pm", int'(pm), 0);
    check("reset.sec_pulse", int'(sec_pulse), 0);
    mode_12h = 1'b1;
    #1;
    check("reset.hr12", int'(hours), 12);
    mode_12h = 1'b0;

    // Free run: ticks after edges 4, 8, ..., 40
    run = 1'b1;
    pcnt = 0; first_idx = -1; last_idx = -1; bad_gap = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (sec_pulse) begin
        if (first_idx < 0) first_idx = i;
        else if (i - last_idx != 4) bad_gap++;
        last_idx = i;
        pcnt++;
      end
    end
    $display("run 40 clocks: %0d sec pulses, seconds=%0d", pcnt, seconds);
    check("run.pulses", pcnt, 10);
    check("run.first", first_idx, 4);
    check("run.gaps", bad_gap, 0);
    check("run.sec", int'(seconds), 10);

    run = 1'b0;
    pcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (sec_pulse) pcnt++;
    end
    $display("pause 20 clocks: %0d sec pulses, seconds=%0d", pcnt, seconds);
    check("pause.pulses", pcnt, 0);
    check("pause.sec", int'(seconds), 10);

    // Day rollover
    run = 1'b1;
    do_load(23, 59, 58);
    chk_time("ld235958", 23, 59, 58);
    check("ld.sec_pulse", int'(sec_pulse), 0);
    step(4);
    chk_time("tick1", 23, 59, 59);
    check("tick1.sec_pulse", int'(sec_pulse), 1);
    check("tick1.day_pulse", int'(day_pulse), 0);
    step(4);
    chk_time("tick2", 0, 0, 0);
    check("tick2.sec_pulse", int'(sec_pulse), 1);
    check("tick2.min_pulse", int'(min_pulse), 1);
    check("tick2.hr_pulse", int'(hr_pulse), 1);
    check("tick2.day_pulse", int'(day_pulse), 1);
    step(1);
    check("tick2.day_clear", int'(day_pulse), 0);

    // 12/24 h display mapping
    run = 1'b0;
    do_load(13, 5, 0);
    mode_12h = 1'b1; #1;
    check("13h.hr12", int'(hours), 1);
    check("13h.pm12", int'(pm), 1);
    mode_12h = 1'b0; #1;
    check("13h.hr24", int'(hours), 13);
    check("13h.pm24", int'(pm), 1);
    do_load(0, 30, 0);
    mode_12h = 1'b1; #1;
    check("0h.hr12", int'(hours), 12);
    check("0h.pm12", int'(pm), 0);
    mode_12h = 1'b0; #1;
    check("0h.hr24", int'(hours), 0);
    do_load(12, 0, 0);
    mode_12h = 1'b1; #1;
    check("12h.hr12", int'(hours), 12);
    check("12h.pm12", int'(pm), 1);
    mode_12h = 1'b0; #1;
    check("12h.hr24", int'(hours), 12);
    check("12h.minutes", int'(minutes), 0);

    // Rejected loads
    do_load(24, 0, 0);
    check("badhr.err", int'(load_err), 1);
    chk_time("badhr", 12, 0, 0);
    step(1);
    check("badhr.err_clear", int'(load_err), 0);
    do_load(1, 60, 0);
    check("badmin.err", int'(load_err), 1);
    chk_time("badmin", 12, 0, 0);

    // Valid load on a tick edge: load wins, no pulse
    run = 1'b1;
    step(3);
    do_load(5, 10, 20);
    chk_time("ldtick", 5, 10, 20);
    check("ldtick.sec_pulse", int'(sec_pulse), 0);
    check("ldtick.err", int'(load_err), 0);
    step(4);
    chk_time("ldtick.next", 5, 10, 21);
    // Invalid load on a tick edge: tick still applies
    step(3);
    do_load(5, 10, 60);
    chk_time("badtick", 5, 10, 22);
    check("badtick.sec_pulse", int'(sec_pulse), 1);
    check("badtick.err", int'(load_err), 1);

    // Alarm
    alarm_en = 1'b1; alarm_hr = 5'd7; alarm_min = 6'd0;
    do_load(6, 59, 58);
    hits = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (alarm_hit) hits++;
      if (i == 8) check("alarm.at_0700", int'(alarm_hit), 1);
    end
    $display("alarm enabled: %0d hits", hits);
    check("alarm.hits", hits, 1);
    check("alarm.sec", int'(seconds), 2);

    alarm_en = 1'b0;
    do_load(6, 59, 58);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (alarm_hit) hits++;
    end
    $display("alarm disabled: %0d hits", hits);
    check("alarm_off.hits", hits, 0);

    alarm_en = 1'b1;
    do_load(7, 0, 0);
    hits = int'(alarm_hit);
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (alarm_hit) hits++;
    end
    $display("alarm direct load: %0d hits", hits);
    check("alarm_load.hits", hits, 0);

    // Asynchronous reset between edges, mid-prescale
    alarm_en = 1'b0;
    do_load(3, 4, 5);
    step(2);
    #2;
    rst = 1'b0;
    #1;
    chk_time("async_rst", 0, 0, 0);
    check("async_rst.sec_pulse", int'(sec_pulse), 0);
    step(1);
    rst = 1'b1;
    step(3);
    check("resume.pre", int'(seconds), 0);
    step(1);
    check("resume.sec", int'(seconds), 1);
    check("resume.sec_pulse", int'(sec_pulse), 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
